// File: rtl/barcode_pkg.sv
// Shared constants for the barcode scanner receive path: PS/2 scancodes,
// the ASCII digit base and the byte receiver state encoding.
package barcode_pkg;

  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  localparam logic [7:0] ASCII_0 = 8'h30;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Returns {is_digit, ascii}; non-digit codes give 9'h000.
  function automatic logic [8:0] sc_to_ascii(input logic [7:0] sc);
    logic [8:0] r;
    r = 9'h000;
    case (sc)
      SC_D0:   r = {1'b1, ASCII_0};
      SC_D1:   r = {1'b1, ASCII_0 + 8'd1};
      SC_D2:   r = {1'b1, ASCII_0 + 8'd2};
      SC_D3:   r = {1'b1, ASCII_0 + 8'd3};
      SC_D4:   r = {1'b1, ASCII_0 + 8'd4};
      SC_D5:   r = {1'b1, ASCII_0 + 8'd5};
      SC_D6:   r = {1'b1, ASCII_0 + 8'd6};
      SC_D7:   r = {1'b1, ASCII_0 + 8'd7};
      SC_D8:   r = {1'b1, ASCII_0 + 8'd8};
      SC_D9:   r = {1'b1, ASCII_0 + 8'd9};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 device-to-host byte receiver: pin synchronizers, falling-edge strobe,
// start/data/parity/stop framing with an inter-edge timeout.
module ps2_byte_rx
  import barcode_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_err
);

  localparam int TMO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             clk_hist_q, fall_q, dat_q;
  rx_state_e        state_q, state_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_ok_q, par_ok_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             byte_valid_q, byte_valid_d;
  logic             rx_err_q, rx_err_d;
  logic             tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q   <= '0;
      dat_sync_q   <= '0;
      clk_hist_q   <= 1'b0;
      fall_q       <= 1'b0;
      dat_q        <= 1'b0;
      state_q      <= RX_IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      tmo_q        <= '0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      dat_sync_q   <= {dat_sync_q[0], ps2_data};
      clk_hist_q   <= clk_sync_q[1];
      // Strobe is registered so data (dat_q) lines up with it in the same cycle.
      fall_q       <= clk_hist_q & ~clk_sync_q[1];
      dat_q        <= dat_sync_q[1];
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      par_ok_q     <= par_ok_d;
      tmo_q        <= tmo_d;
      byte_valid_q <= byte_valid_d;
      rx_err_q     <= rx_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    par_ok_d     = par_ok_q;
    tmo_d        = '0;
    byte_valid_d = 1'b0;
    rx_err_d     = 1'b0;
    tmo_hit      = (state_q != RX_IDLE) && !fall_q && (tmo_q == TMO_W'(TMO_CYC - 1));

    if (state_q != RX_IDLE && !fall_q) tmo_d = tmo_q + 1'b1;

    if (tmo_hit) begin
      state_d  = RX_IDLE;
      rx_err_d = 1'b1;
      tmo_d    = '0;
    end else if (fall_q) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_q) begin
            state_d  = RX_DATA;
            bitcnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d  = {dat_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_ok_d = ^{shift_q, dat_q};
          state_d  = RX_STOP;
        end
        RX_STOP: begin
          if (dat_q && par_ok_q) byte_valid_d = 1'b1;
          else                   rx_err_d     = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign rx_err     = rx_err_q;

endmodule

// File: rtl/barcode_frame_rx.sv
// Barcode scanner frame receiver: decodes PS/2 scancodes into ASCII digits and
// publishes a complete NCHAR-digit code on Enter, holding it until the next good one.
module barcode_frame_rx
  import barcode_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_US = 2000,
  parameter int NCHAR      = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               scan_en,
  output logic [8*NCHAR-1:0] frame_data,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               rx_err,
  output logic [3:0]         char_cnt
);

  localparam logic [3:0] CNT_FULL = 4'(NCHAR);

  logic [7:0]         rx_byte;
  logic               byte_valid;
  logic [8:0]         dig;

  logic               brk_q, brk_d;
  logic               ext_q, ext_d;
  logic               ovf_q, ovf_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [8*NCHAR-1:0] work_q, work_d;
  logic [8*NCHAR-1:0] frame_data_q, frame_data_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q, frame_err_d;

  ps2_byte_rx #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .rx_err    (rx_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
      ovf_q         <= 1'b0;
      cnt_q         <= '0;
      work_q        <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      brk_q         <= brk_d;
      ext_q         <= ext_d;
      ovf_q         <= ovf_d;
      cnt_q         <= cnt_d;
      work_q        <= work_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  always_comb begin
    brk_d         = brk_q;
    ext_d         = ext_q;
    ovf_d         = ovf_q;
    cnt_d         = cnt_q;
    work_d        = work_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    dig           = sc_to_ascii(rx_byte);

    if (!scan_en) begin
      brk_d  = 1'b0;
      ext_d  = 1'b0;
      ovf_d  = 1'b0;
      cnt_d  = '0;
      work_d = '0;
    end else if (byte_valid) begin
      // Any byte consumes a pending E0 prefix; only a fresh E0 re-arms it.
      ext_d = 1'b0;
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_ENTER) begin
        if (cnt_q != 4'd0) begin
          if (cnt_q == CNT_FULL && !ovf_q) begin
            frame_data_d  = work_q;
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          work_d = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
        end
      end else if (dig[8]) begin
        if (cnt_q < CNT_FULL) begin
          work_d = {work_q[8*NCHAR-9:0], dig[7:0]};
          cnt_d  = cnt_q + 4'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign char_cnt    = cnt_q;

endmodule

// File: tb/tb_barcode_frame_rx.sv
// Directed bench for barcode_frame_rx: PS/2 frames are bit-banged at 16 clk per
// bit, with a shortened timeout (50 clk) so the stall case stays short.
module tb_barcode_frame_rx;

  localparam int NCHAR = 13;

  logic               clk      = 1'b0;
  logic               rst_n    = 1'b0;
  logic               ps2_clk  = 1'b1;
  logic               ps2_data = 1'b1;
  logic               scan_en  = 1'b1;
  logic [8*NCHAR-1:0] frame_data;
  logic               frame_valid;
  logic               frame_err;
  logic               rx_err;
  logic [3:0]         char_cnt;

  int vectors     = 0;
  int miscompares = 0;

  int fv_n = 0, fe_n = 0, re_n = 0;
  bit fv_long = 1'b0, fe_long = 1'b0, overlap = 1'b0;
  bit fv_prev = 1'b0, fe_prev = 1'b0;
  int fv0, fe0, re0;

  logic [7:0]         dcode [10];
  logic [8*NCHAR-1:0] code1, code4;

  always #5 clk = ~clk;

  barcode_frame_rx #(
    .CLK_HZ    (1_000_000),
    .TIMEOUT_US(50),
    .NCHAR     (NCHAR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_en    (scan_en),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .rx_err     (rx_err),
    .char_cnt   (char_cnt)
  );

  always @(negedge clk) begin
    if (frame_valid) fv_n++;
    if (frame_err)   fe_n++;
    if (rx_err)      re_n++;
    if (frame_valid && fv_prev) fv_long = 1'b1;
    if (frame_err && fe_prev)   fe_long = 1'b1;
    if (frame_valid && frame_err) overlap = 1'b1;
    fv_prev = frame_valid;
    fe_prev = frame_err;
  end

  task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (4) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad_par ? ^b : ~^b);
    send_bit(1'b1);
    ps2_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic scan(input string s, input bit with_brk, input int bad_idx);
    int d;
    for (int i = 0; i < s.len(); i++) begin
      d = int'(s[i]) - 48;
      send_byte(dcode[d], i == bad_idx);
      if (with_brk) begin
        send_byte(8'hF0, 1'b0);
        send_byte(dcode[d], 1'b0);
      end
    end
  endtask

  task automatic enter();
    send_byte(8'h5A, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h5A, 1'b0);
  endtask

  task automatic snap();
    fv0 = fv_n;
    fe0 = fe_n;
    re0 = re_n;
  endtask

  initial begin
    dcode[0] = 8'h45; dcode[1] = 8'h16; dcode[2] = 8'h1E; dcode[3] = 8'h26;
    dcode[4] = 8'h25; dcode[5] = 8'h2E; dcode[6] = 8'h36; dcode[7] = 8'h3D;
    dcode[8] = 8'h3E; dcode[9] = 8'h46;
    code1 = 104'h39_37_38_37_33_35_38_39_37_35_32_39_30;
    code4 = 104'h31_30_30_30_30_30_30_30_30_30_30_30_37;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_frame_data", 104'(frame_data), 104'h0);
    check("rst_frame_valid", 104'(frame_valid), 104'h0);
    check("rst_frame_err", 104'(frame_err), 104'h0);
    check("rst_rx_err", 104'(rx_err), 104'h0);
    check("rst_char_cnt", 104'(char_cnt), 104'h0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // 1: full scan with break codes, then Enter
    snap();
    scan("9787358975290", 1'b1, -1);
    @(negedge clk);
    check("t1_cnt_13", 104'(char_cnt), 104'd13);
    enter();
    @(negedge clk);
    check("t1_frame_data", 104'(frame_data), code1);
    check("t1_valid_pulses", 104'(fv_n - fv0), 104'd1);
    check("t1_err_pulses", 104'(fe_n - fe0), 104'd0);
    check("t1_cnt_zero", 104'(char_cnt), 104'd0);

    // 2: parity error on the 5th digit, Enter at 12 digits
    snap();
    scan("9787358975290", 1'b0, 4);
    @(negedge clk);
    check("t2_rx_err", 104'(re_n - re0), 104'd1);
    check("t2_cnt_12", 104'(char_cnt), 104'd12);
    enter();
    @(negedge clk);
    check("t2_frame_err", 104'(fe_n - fe0), 104'd1);
    check("t2_no_valid", 104'(fv_n - fv0), 104'd0);
    check("t2_data_held", 104'(frame_data), code1);

    // 3: 14 digits overflow, then keypad Enter on a good scan
    snap();
    scan("97873589752901", 1'b0, -1);
    @(negedge clk);
    check("t3_cnt_sat", 104'(char_cnt), 104'd13);
    enter();
    @(negedge clk);
    check("t3_ovf_err", 104'(fe_n - fe0), 104'd1);
    check("t3_ovf_no_valid", 104'(fv_n - fv0), 104'd0);
    check("t3_ovf_cnt0", 104'(char_cnt), 104'd0);
    snap();
    scan("1234567890123", 1'b0, -1);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h5A, 1'b0);
    @(negedge clk);
    check("t3_kp_valid", 104'(fv_n - fv0), 104'd1);
    check("t3_kp_no_err", 104'(fe_n - fe0), 104'd0);
    check("t3_kp_data", 104'(frame_data), 104'h31_32_33_34_35_36_37_38_39_30_31_32_33);

    // 4: clock stall after 4 data bits
    snap();
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    check("t4_timeout_err", 104'(re_n - re0), 104'd1);
    check("t4_cnt_zero", 104'(char_cnt), 104'd0);
    send_byte(8'h16, 1'b0);
    @(negedge clk);
    check("t4_next_byte_cnt", 104'(char_cnt), 104'd1);
    check("t4_no_extra_err", 104'(re_n - re0), 104'd1);
    scan("000000000007", 1'b0, -1);
    enter();
    @(negedge clk);
    check("t4_valid", 104'(fv_n - fv0), 104'd1);
    check("t4_data", 104'(frame_data), code4);

    // 5: scan_en dropped mid-frame
    snap();
    scan("123456", 1'b0, -1);
    @(negedge clk);
    check("t5_cnt_6", 104'(char_cnt), 104'd6);
    scan_en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t5_cnt_cleared", 104'(char_cnt), 104'd0);
    send_byte(dcode[7], 1'b0);
    @(negedge clk);
    check("t5_disabled_drop", 104'(char_cnt), 104'd0);
    scan_en = 1'b1;
    repeat (5) @(posedge clk);
    scan("7654321", 1'b0, -1);
    @(negedge clk);
    check("t5_cnt_7", 104'(char_cnt), 104'd7);
    enter();
    @(negedge clk);
    check("t5_frame_err", 104'(fe_n - fe0), 104'd1);
    check("t5_no_valid", 104'(fv_n - fv0), 104'd0);
    check("t5_data_held", 104'(frame_data), code4);

    // 6: reset mid-byte with a partial frame pending
    scan("12", 1'b0, -1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_rst_data", 104'(frame_data), 104'h0);
    check("t6_rst_cnt", 104'(char_cnt), 104'h0);
    check("t6_rst_flags", 104'({frame_valid, frame_err, rx_err}), 104'h0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rst_n    = 1'b1;
    repeat (10) @(posedge clk);
    snap();
    scan("9787358975280", 1'b0, -1);
    enter();
    @(negedge clk);
    check("t6_valid", 104'(fv_n - fv0), 104'd1);
    check("t6_no_err", 104'(fe_n - fe0), 104'd0);
    check("t6_data", 104'(frame_data), 104'h39_37_38_37_33_35_38_39_37_35_32_38_30);

    // Pulse shape over the whole run
    check("valid_one_cycle", 104'(fv_long), 104'd0);
    check("err_one_cycle", 104'(fe_long), 104'd0);
    check("valid_err_exclusive", 104'(overlap), 104'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
